stepper_motors_ctrl: RTL and testbench

Responder end of the motors control interface: accepts a move command (pulse count and direction per axis) from an op handler, drives step/dir outputs to the X and Y stepper drivers at a fixed pulse rate, and reports completion. Both axes step concurrently; the move completes when the axis with more pulses finishes. It sits between the op handlers and the stepper driver pins.

---
 rtl/motors_pkg.sv | 24 ++
 rtl/step_axis.sv | 51 +++++
 rtl/stepper_motors_ctrl.sv | 117 +++++++++++
 tb/tb_stepper_motors_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/motors_pkg.sv
// Shared types and constants for the stepper motors controller.
// Holds the move FSM state encoding and default parameter values.
package motors_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      RUN,
      DONE
   } state_t;

   localparam int DEF_X_BITS = 16;
   localparam int DEF_Y_BITS = 16;
   localparam int DEF_HIGH   = 2;
   localparam int DEF_PERIOD = 8;

   localparam int CNT_W = $clog2(DEF_PERIOD);

   // Period counter width for a given period, never below one bit.
   function automatic int cnt_w(input int p);
      return (p <= 2) ? 1 : $clog2(p);
   endfunction

endpackage

// File: rtl/step_axis.sv
// One stepper axis: remaining-pulse counter and step output.
// The step is timed by the period count shared from the top.
module step_axis
   import motors_pkg::*;
#(
   parameter int BITS = 16,
   parameter int CW   = 3,
   parameter int HIGH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clk_en,
   input  logic            load,
   input  logic            run,
   input  logic [CW-1:0]   cnt,
   input  logic [BITS-1:0] num,
   output logic            step,
   output logic            busy
);

   logic [BITS-1:0] rem;
   logic            pulsing;

   assign busy = (rem != '0);

   // Load on accept; consume one pulse at the start of each period.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem     <= '0;
         pulsing <= 1'b0;
      end else if (clk_en) begin
         if (load) begin
            rem     <= num;
            pulsing <= 1'b0;
         end else if (run && cnt == '0) begin
            pulsing <= busy;
            if (busy) rem <= rem - 1'b1;
         end
      end
   end

   // High from count 0 while the pulse started this period lasts.
   always_comb begin
      step = 1'b0;
      if (run) begin
         if (cnt == '0) step = busy;
         else           step = pulsing && (cnt < CW'(HIGH));
      end
   end

endmodule

// File: rtl/stepper_motors_ctrl.sv
// Two-axis stepper move controller with a trigger/rdy/done handshake.
// Both axes step concurrently off one shared period counter.
module stepper_motors_ctrl
   import motors_pkg::*;
#(
   parameter int PULSE_NUM_X_BITS   = DEF_X_BITS,
   parameter int PULSE_NUM_Y_BITS   = DEF_Y_BITS,
   parameter int PULSE_HIGH_TICKS   = DEF_HIGH,
   parameter int PULSE_PERIOD_TICKS = DEF_PERIOD
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clk_en,
   input  logic                        trigger,
   input  logic [PULSE_NUM_X_BITS-1:0] pulse_num_x,
   input  logic [PULSE_NUM_Y_BITS-1:0] pulse_num_y,
   input  logic                        dir_x_in,
   input  logic                        dir_y_in,
   output logic                        rdy,
   output logic                        done,
   output logic                        step_x,
   output logic                        step_y,
   output logic                        dir_x,
   output logic                        dir_y
);

   localparam int CW = cnt_w(PULSE_PERIOD_TICKS);
   localparam logic [CW-1:0] LAST = CW'(PULSE_PERIOD_TICKS - 1);

   state_t        state;
   state_t        nstate;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          run;
   logic          busy_x;
   logic          busy_y;

   assign accept = (state == IDLE) && trigger;
   assign run    = (state == RUN);
   assign rdy    = (state == IDLE);
   assign done   = (state == DONE);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      state <= IDLE;
      else if (clk_en) state <= nstate;
   end

   // Next-state logic for the move sequence.
   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:  if (trigger) nstate = SETUP;
         SETUP: nstate = (busy_x || busy_y) ? RUN : DONE;
         RUN:   if (cnt == LAST && !busy_x && !busy_y)
                   nstate = DONE;
         DONE:  nstate = IDLE;
      endcase
   end

   // Shared period counter, parked at zero outside RUN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clk_en) begin
         unique case (1'b1)
            !run:         cnt <= '0;
            cnt == LAST:  cnt <= '0;
            default:      cnt <= cnt + 1'b1;
         endcase
      end
   end

   // Directions latched once per accepted move.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dir_x <= 1'b0;
         dir_y <= 1'b0;
      end else if (clk_en && accept) begin
         dir_x <= dir_x_in;
         dir_y <= dir_y_in;
      end
   end

   step_axis #(
      .BITS (PULSE_NUM_X_BITS),
      .CW   (CW),
      .HIGH (PULSE_HIGH_TICKS)
   ) u_axis_x (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .load   (accept),
      .run    (run),
      .cnt    (cnt),
      .num    (pulse_num_x),
      .step   (step_x),
      .busy   (busy_x)
   );

   step_axis #(
      .BITS (PULSE_NUM_Y_BITS),
      .CW   (CW),
      .HIGH (PULSE_HIGH_TICKS)
   ) u_axis_y (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .load   (accept),
      .run    (run),
      .cnt    (cnt),
      .num    (pulse_num_y),
      .step   (step_y),
      .busy   (busy_y)
   );

endmodule

// File: tb/tb_stepper_motors_ctrl.sv
// Bench for stepper_motors_ctrl: expected waveforms come from the
// move timing rules (pulse k at 2+kP, done at 2+NP) per clk_en tick.
module tb_stepper_motors_ctrl;

   localparam int P = 8;
   localparam int H = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clk_en = 1'b0;
   logic        trigger = 1'b0;
   logic [15:0] pulse_num_x = '0;
   logic [15:0] pulse_num_y = '0;
   logic        dir_x_in = 1'b0;
   logic        dir_y_in = 1'b0;
   logic        sel = 1'b0;

   logic rdy_b, done_b, sx_b, sy_b, dx_b, dy_b;
   logic rdy_s, done_s, sx_s, sy_s, dx_s, dy_s;
   logic trig_b, trig_s;
   logic o_rdy, o_done, o_sx, o_sy, o_dx, o_dy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign trig_b = trigger & ~sel;
   assign trig_s = trigger & sel;

   assign o_rdy  = sel ? rdy_s  : rdy_b;
   assign o_done = sel ? done_s : done_b;
   assign o_sx   = sel ? sx_s   : sx_b;
   assign o_sy   = sel ? sy_s   : sy_b;
   assign o_dx   = sel ? dx_s   : dx_b;
   assign o_dy   = sel ? dy_s   : dy_b;

   stepper_motors_ctrl #(
      .PULSE_NUM_X_BITS   (16),
      .PULSE_NUM_Y_BITS   (16),
      .PULSE_HIGH_TICKS   (H),
      .PULSE_PERIOD_TICKS (P)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clk_en      (clk_en),
      .trigger     (trig_b),
      .pulse_num_x (pulse_num_x),
      .pulse_num_y (pulse_num_y),
      .dir_x_in    (dir_x_in),
      .dir_y_in    (dir_y_in),
      .rdy         (rdy_b),
      .done        (done_b),
      .step_x      (sx_b),
      .step_y      (sy_b),
      .dir_x       (dx_b),
      .dir_y       (dy_b)
   );

   stepper_motors_ctrl #(
      .PULSE_NUM_X_BITS   (4),
      .PULSE_NUM_Y_BITS   (4),
      .PULSE_HIGH_TICKS   (H),
      .PULSE_PERIOD_TICKS (P)
   ) dut_small (
      .clk         (clk),
      .reset       (reset),
      .clk_en      (clk_en),
      .trigger     (trig_s),
      .pulse_num_x (pulse_num_x[3:0]),
      .pulse_num_y (pulse_num_y[3:0]),
      .dir_x_in    (dir_x_in),
      .dir_y_in    (dir_y_in),
      .rdy         (rdy_s),
      .done        (done_s),
      .step_x      (sx_s),
      .step_y      (sy_s),
      .dir_x       (dx_s),
      .dir_y       (dy_s)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic exp_step(input int n, input int d);
      if (d < 2) return 1'b0;
      return ((d - 2) / P < n) && ((d - 2) % P < H);
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rdy"},  o_rdy,  1'b1);
      chk({tag, "_done"}, o_done, 1'b0);
      chk({tag, "_sx"},   o_sx,   1'b0);
      chk({tag, "_sy"},   o_sy,   1'b0);
      chk({tag, "_dx"},   o_dx,   1'b0);
      chk({tag, "_dy"},   o_dy,   1'b0);
   endtask

   // mode 0: clk_en always 1, 1: alternating, 2: random
   task automatic run_move(input int x, input int y,
                           input logic dx, input logic dy,
                           input int mode, input bit hold);
      int   n;
      int   k;
      int   guard;
      logic en;
      n = (x > y) ? x : y;
      k = 0;
      guard = 0;
      chk("idle_rdy", o_rdy, 1'b1);
      chk("idle_done", o_done, 1'b0);
      trigger     = 1'b1;
      clk_en      = 1'b1;
      en          = 1'b1;
      pulse_num_x = 16'(x);
      pulse_num_y = 16'(y);
      dir_x_in    = dx;
      dir_y_in    = dy;
      while (k < 3 + n * P) begin
         @(posedge clk);
         if (clk_en) k++;
         @(negedge clk);
         chk("rdy",    o_rdy,  k >= 3 + n * P);
         chk("done",   o_done, k == 2 + n * P);
         chk("step_x", o_sx,   exp_step(x, k));
         chk("step_y", o_sy,   exp_step(y, k));
         chk("dir_x",  o_dx,   dx);
         chk("dir_y",  o_dy,   dy);
         guard++;
         if (guard > 20000) begin
            chk("move_timeout", 1'b1, 1'b0);
            break;
         end
         case (mode)
            0:       en = 1'b1;
            1:       en = ~en;
            default: en = 1'($urandom_range(0, 1));
         endcase
         clk_en      = en;
         trigger     = hold ? 1'b1 : 1'($urandom_range(0, 1));
         pulse_num_x = 16'($urandom);
         pulse_num_y = 16'($urandom);
         dir_x_in    = 1'($urandom);
         dir_y_in    = 1'($urandom);
      end
      if (!hold) trigger = 1'b0;
      clk_en = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      sel = 1'b0;
      chk_reset_vals("rst_held");
      sel = 1'b1;
      chk_reset_vals("rst_held_s");
      reset  = 1'b1;
      clk_en = 1'b1;
      @(negedge clk);
      sel = 1'b0;
      chk_reset_vals("rst_rel");
      sel = 1'b1;
      chk_reset_vals("rst_rel_s");
      sel = 1'b0;

      run_move(3, 1, 1'b1, 1'b0, 0, 1'b0);
      run_move(0, 0, 1'b1, 1'b1, 0, 1'b0);
      run_move(2, 2, 1'b0, 1'b1, 0, 1'b1);
      run_move(1, 3, 1'b1, 1'b1, 0, 1'b0);
      run_move(1, 0, 1'b1, 1'b0, 1, 1'b0);

      sel = 1'b1;
      run_move(15, 0, 1'b1, 1'b0, 0, 1'b0);
      run_move(0, 15, 1'b0, 1'b1, 2, 1'b0);
      sel = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_move(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                  1'($urandom), 1'($urandom), 2, 1'($urandom));
      end
      trigger = 1'b0;
      @(negedge clk);

      // Reset asserted while the first pulse is high.
      chk("mid_rdy0", o_rdy, 1'b1);
      pulse_num_x = 16'd3;
      pulse_num_y = 16'd1;
      dir_x_in    = 1'b1;
      dir_y_in    = 1'b1;
      trigger     = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      @(negedge clk);
      chk("mid_step_x", o_sx, 1'b1);
      chk("mid_dir_x",  o_dx, 1'b1);
      #2 reset = 1'b0;
      #1 chk_reset_vals("rst_mid");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("rst_after");
      run_move(2, 1, 1'b0, 1'b1, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
